// File: rtl/wired_wkupsrc_if.sv
// Bundle of the FU result, wakeup broadcast and writeback signals of wired_wkupsrc.
// master is the broadcaster itself; slave is the FU / issue queue / writeback side.
interface wired_wkupsrc_if #(
    parameter int RID_WIDTH = 6
);
    logic                 flush_i;
    logic                 fu_ready_o;
    logic                 fu_pre_valid_i;
    logic [RID_WIDTH-1:0] fu_pre_rid_i;
    logic                 fu_valid_i;
    logic [RID_WIDTH-1:0] fu_rid_i;
    logic [31:0]          fu_data_i;
    logic                 wkup_valid_o;
    logic [RID_WIDTH-1:0] wkup_rid_o;
    logic [31:0]          wkup_data_o;
    logic                 wb_valid_o;
    logic                 wb_ready_i;
    logic [RID_WIDTH-1:0] wb_rid_o;
    logic [31:0]          wb_data_o;
    logic                 err_o;

    modport master (
        input  flush_i, fu_pre_valid_i, fu_pre_rid_i, fu_valid_i, fu_rid_i, fu_data_i, wb_ready_i,
        output fu_ready_o, wkup_valid_o, wkup_rid_o, wkup_data_o, wb_valid_o, wb_rid_o, wb_data_o, err_o
    );

    modport slave (
        output flush_i, fu_pre_valid_i, fu_pre_rid_i, fu_valid_i, fu_rid_i, fu_data_i, wb_ready_i,
        input  fu_ready_o, wkup_valid_o, wkup_rid_o, wkup_data_o, wb_valid_o, wb_rid_o, wb_data_o, err_o
    );
endinterface

// File: rtl/wired_wkupsrc.sv
// Wakeup broadcaster: tag one cycle ahead of data, results queued in a credit-guarded
// writeback FIFO so the broadcast path never has to stall.
module wired_wkupsrc #(
    parameter int RID_WIDTH = 6,
    parameter int WB_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wired_wkupsrc_if.master bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(WB_DEPTH);

    logic                 pre_valid_reg;
    logic [RID_WIDTH-1:0] pre_rid_reg;
    logic [31:0]          wkup_data_reg;
    logic                 err_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [RID_WIDTH+31:0] entry_arr [WB_DEPTH];

    logic           fu_ready;
    logic [CNT_W:0] credit_sum;
    logic           accept_pre;
    logic           push;
    logic           pop;
    logic           proto_err;

    // Credit counts the in-flight announced result as already occupying a slot.
    assign credit_sum = {1'b0, count_reg} + {{CNT_W{1'b0}}, pre_valid_reg};
    assign fu_ready   = credit_sum < DEPTH_C;

    assign accept_pre = bus.fu_pre_valid_i & fu_ready & ~bus.flush_i;
    assign push       = pre_valid_reg & bus.fu_valid_i & ~bus.flush_i;
    assign pop        = (count_reg != '0) & bus.wb_ready_i & ~bus.flush_i;
    assign proto_err  = ~bus.flush_i &
                        ((pre_valid_reg & ~bus.fu_valid_i) |
                         (~pre_valid_reg & bus.fu_valid_i) |
                         (push & (bus.fu_rid_i != pre_rid_reg)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_valid_reg <= 1'b0;
            pre_rid_reg   <= '0;
            wkup_data_reg <= '0;
            err_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            err_reg <= err_reg | proto_err;
            if (push)
                wkup_data_reg <= bus.fu_data_i;
            if (bus.flush_i) begin
                pre_valid_reg <= 1'b0;
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
            end else begin
                pre_valid_reg <= accept_pre;
                if (accept_pre)
                    pre_rid_reg <= bus.fu_pre_rid_i;
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Entries are reset so the head reads as zero straight out of reset.
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_entry
        logic [RID_WIDTH+31:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                entry_reg <= '0;
            else if (push && (wr_ptr_reg == PTR_W'(gi)))
                entry_reg <= {pre_rid_reg, bus.fu_data_i};
        end

        assign entry_arr[gi] = entry_reg;
    end

    assign bus.fu_ready_o   = fu_ready;
    assign bus.wkup_valid_o = pre_valid_reg;
    assign bus.wkup_rid_o   = pre_rid_reg;
    assign bus.wkup_data_o  = wkup_data_reg;
    assign bus.wb_valid_o   = (count_reg != '0);
    assign bus.wb_rid_o     = entry_arr[rd_ptr_reg][RID_WIDTH+31:32];
    assign bus.wb_data_o    = entry_arr[rd_ptr_reg][31:0];
    assign bus.err_o        = err_reg;
endmodule

// File: tb/tb_wired_wkupsrc.sv
// Directed bench for wired_wkupsrc: per-scenario tasks with hand-computed expectations.
module tb_wired_wkupsrc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wired_wkupsrc_if #(.RID_WIDTH(6)) bus ();

    wired_wkupsrc #(.RID_WIDTH(6), .WB_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i        = 1'b0;
        bus.fu_pre_valid_i = 1'b0;
        bus.fu_pre_rid_i   = '0;
        bus.fu_valid_i     = 1'b0;
        bus.fu_rid_i       = '0;
        bus.fu_data_i      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.wb_ready_i = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        n_tests++; if (bus.wkup_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wkup_valid: got %0b want 0", bus.wkup_valid_o); end
        n_tests++; if (bus.wkup_rid_o !== 6'd0) begin n_fail++; $display("FAIL reset_wkup_rid: got %0d want 0", bus.wkup_rid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_wkup_data: got %h want 0", bus.wkup_data_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if (bus.wb_rid_o !== 6'd0) begin n_fail++; $display("FAIL reset_wb_rid: got %0d want 0", bus.wb_rid_o); end
        n_tests++; if (bus.wb_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_data_o); end
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.err_o); end
        n_tests++; if (bus.fu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fu_ready: got %0b want 1", bus.fu_ready_o); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        bus.wb_ready_i = 1'b0;
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd5;
        n_tests++; if (bus.fu_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", bus.fu_ready_o); end
        step();
        idle_inputs();
        bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd5; bus.fu_data_i = 32'hDEADBEEF;
        n_tests++; if (bus.wkup_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_wkup_t1: got %0b want 1", bus.wkup_valid_o); end
        n_tests++; if (bus.wkup_rid_o !== 6'd5) begin n_fail++; $display("FAIL single_wkup_rid: got %0d want 5", bus.wkup_rid_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_wb_early: got %0b want 0", bus.wb_valid_o); end
        step();
        idle_inputs();
        n_tests++; if (bus.wkup_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_wkup_t2: got %0b want 0", bus.wkup_valid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data_t2: got %h want deadbeef", bus.wkup_data_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid: got %0b want 1", bus.wb_valid_o); end
        n_tests++; if (bus.wb_rid_o !== 6'd5) begin n_fail++; $display("FAIL single_wb_rid: got %0d want 5", bus.wb_rid_o); end
        n_tests++; if (bus.wb_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wb_data: got %h want deadbeef", bus.wb_data_o); end
        $display("[TB] single pop rid=%0d data=%h", bus.wb_rid_o, bus.wb_data_o);
        bus.wb_ready_i = 1'b1;
        step();
        bus.wb_ready_i = 1'b0;
        n_tests++; if (bus.wkup_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data_hold: got %h want deadbeef", bus.wkup_data_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_wb_empty: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %0b want 0", bus.err_o); end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c < 4) begin bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'(c + 1); end
            if (c >= 1) begin
                bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'(c); bus.fu_data_i = 32'hB000_0000 + 32'(c);
                n_tests++; if (bus.wkup_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_wkup_valid c%0d: got %0b want 1", c, bus.wkup_valid_o); end
                n_tests++; if (bus.wkup_rid_o !== 6'(c)) begin n_fail++; $display("FAIL b2b_wkup_rid c%0d: got %0d want %0d", c, bus.wkup_rid_o, c); end
            end
            n_tests++; if (bus.fu_ready_o !== (c != 4)) begin n_fail++; $display("FAIL b2b_ready c%0d: got %0b want %0b", c, bus.fu_ready_o, c != 4); end
            step();
        end
        idle_inputs();
        n_tests++; if (bus.fu_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %0b want 0", bus.fu_ready_o); end
        n_tests++; if (bus.wkup_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_wkup_end: got %0b want 0", bus.wkup_valid_o); end
        bus.wb_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_tests++; if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_valid %0d: got %0b want 1", k, bus.wb_valid_o); end
            n_tests++; if (bus.wb_rid_o !== 6'(k)) begin n_fail++; $display("FAIL b2b_pop_rid %0d: got %0d want %0d", k, bus.wb_rid_o, k); end
            n_tests++; if (bus.wb_data_o !== 32'hB000_0000 + 32'(k)) begin n_fail++; $display("FAIL b2b_pop_data %0d: got %h want %h", k, bus.wb_data_o, 32'hB000_0000 + 32'(k)); end
            n_tests++; if (bus.fu_ready_o !== (k != 1)) begin n_fail++; $display("FAIL b2b_pop_ready %0d: got %0b want %0b", k, bus.fu_ready_o, k != 1); end
            $display("[TB] b2b pop rid=%0d data=%h", bus.wb_rid_o, bus.wb_data_o);
            step();
        end
        bus.wb_ready_i = 1'b0;
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0b want 0", bus.wb_valid_o); end
    endtask

    task automatic test_wrap();
        logic [37:0] q[$];
        logic        pend = 1'b0;
        logic        new_pend;
        logic [5:0]  pend_rid = '0;
        logic [5:0]  new_rid;
        logic        exp_ready;
        int          sent = 0;
        int          got = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            idle_inputs();
            bus.wb_ready_i = (cyc % 2 == 0);
            exp_ready = (q.size() + int'(pend)) < 4;
            n_tests++; if (bus.fu_ready_o !== exp_ready) begin n_fail++; $display("FAIL wrap_ready cyc%0d: got %0b want %0b", cyc, bus.fu_ready_o, exp_ready); end
            n_tests++; if (bus.wkup_valid_o !== pend) begin n_fail++; $display("FAIL wrap_wkup cyc%0d: got %0b want %0b", cyc, bus.wkup_valid_o, pend); end
            n_tests++; if (bus.wb_valid_o !== (q.size() != 0)) begin n_fail++; $display("FAIL wrap_wb_valid cyc%0d: got %0b want %0b", cyc, bus.wb_valid_o, q.size() != 0); end
            if (q.size() != 0 && bus.wb_ready_i) begin
                n_tests++; if ({bus.wb_rid_o, bus.wb_data_o} !== q[0]) begin n_fail++; $display("FAIL wrap_pop %0d: got %h want %h", got, {bus.wb_rid_o, bus.wb_data_o}, q[0]); end
                $display("[TB] wrap pop rid=%0d data=%h", bus.wb_rid_o, bus.wb_data_o);
                void'(q.pop_front());
                got++;
            end
            if (pend) begin
                bus.fu_valid_i = 1'b1; bus.fu_rid_i = pend_rid; bus.fu_data_i = 32'hA5A5_0000 | 32'(pend_rid);
                q.push_back({pend_rid, 32'hA5A5_0000 | 32'(pend_rid)});
            end
            new_pend = 1'b0;
            new_rid  = '0;
            if (sent < 10 && exp_ready) begin
                new_rid = 6'(sent + 10);
                bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = new_rid;
                new_pend = 1'b1;
                sent++;
            end
            step();
            pend = new_pend;
            pend_rid = new_rid;
        end
        idle_inputs();
        bus.wb_ready_i = 1'b0;
        n_tests++; if (got != 10) begin n_fail++; $display("FAIL wrap_count: got %0d pops want 10", got); end
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %0b want 0", bus.err_o); end
    endtask

    task automatic test_flush();
        bus.wb_ready_i = 1'b0;
        idle_inputs(); bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd20;
        step();
        idle_inputs(); bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd20; bus.fu_data_i = 32'h1111_0020;
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd21;
        step();
        idle_inputs(); bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd21; bus.fu_data_i = 32'h1111_0021;
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd7;
        step();
        idle_inputs(); bus.flush_i = 1'b1;
        bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd7; bus.fu_data_i = 32'h7777_7777;
        n_tests++; if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_wb: got %0b want 1", bus.wb_valid_o); end
        n_tests++; if (bus.wkup_rid_o !== 6'd7) begin n_fail++; $display("FAIL flush_pre_rid: got %0d want 7", bus.wkup_rid_o); end
        step();
        idle_inputs();
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if (bus.wkup_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wkup: got %0b want 0", bus.wkup_valid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'h1111_0021) begin n_fail++; $display("FAIL flush_data: got %h want 11110021", bus.wkup_data_o); end
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %0b want 0", bus.err_o); end
        n_tests++; if (bus.fu_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", bus.fu_ready_o); end
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd8;
        step();
        idle_inputs(); bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd8; bus.fu_data_i = 32'h8888_8888;
        step();
        idle_inputs();
        n_tests++; if (bus.wkup_data_o !== 32'h8888_8888) begin n_fail++; $display("FAIL flush_after_data: got %h want 88888888", bus.wkup_data_o); end
        n_tests++; if ({bus.wb_valid_o, bus.wb_rid_o, bus.wb_data_o} !== {1'b1, 6'd8, 32'h8888_8888}) begin n_fail++; $display("FAIL flush_after_head: got %0b/%0d/%h want 1/8/88888888", bus.wb_valid_o, bus.wb_rid_o, bus.wb_data_o); end
        $display("[TB] flush pop rid=%0d data=%h", bus.wb_rid_o, bus.wb_data_o);
        bus.wb_ready_i = 1'b1;
        step();
        bus.wb_ready_i = 1'b0;
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_after_empty: got %0b want 0", bus.wb_valid_o); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd9;
        step();
        idle_inputs();
        n_tests++; if (bus.wkup_rid_o !== 6'd9) begin n_fail++; $display("FAIL err_missing_rid: got %0d want 9", bus.wkup_rid_o); end
        step();
        n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_missing: got %0b want 1", bus.err_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_missing_push: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'd0) begin n_fail++; $display("FAIL err_missing_data: got %h want 0", bus.wkup_data_o); end
        step();
        step();
        n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", bus.err_o); end
        do_reset();
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %0b want 0", bus.err_o); end
        bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'd3;
        step();
        idle_inputs(); bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd4; bus.fu_data_i = 32'h0000_1234;
        step();
        idle_inputs();
        n_tests++; if ({bus.wb_valid_o, bus.wb_rid_o, bus.wb_data_o} !== {1'b1, 6'd3, 32'h0000_1234}) begin n_fail++; $display("FAIL err_mismatch_head: got %0b/%0d/%h want 1/3/00001234", bus.wb_valid_o, bus.wb_rid_o, bus.wb_data_o); end
        n_tests++; if (bus.wkup_data_o !== 32'h0000_1234) begin n_fail++; $display("FAIL err_mismatch_data: got %h want 00001234", bus.wkup_data_o); end
        n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_mismatch: got %0b want 1", bus.err_o); end
        do_reset();
        bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'd2; bus.fu_data_i = 32'h0000_0055;
        step();
        idle_inputs();
        n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_unexpected: got %0b want 1", bus.err_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_unexpected_push: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'd0) begin n_fail++; $display("FAIL err_unexpected_data: got %h want 0", bus.wkup_data_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            bus.fu_pre_valid_i = 1'b1; bus.fu_pre_rid_i = 6'(30 + c);
            if (c >= 1) begin bus.fu_valid_i = 1'b1; bus.fu_rid_i = 6'(29 + c); bus.fu_data_i = 32'hC000_0000 + 32'(c); end
            step();
        end
        idle_inputs();
        n_tests++; if ({bus.wb_valid_o, bus.wkup_valid_o, bus.fu_ready_o} !== 3'b110) begin n_fail++; $display("FAIL mid_setup: got %b want 110", {bus.wb_valid_o, bus.wkup_valid_o, bus.fu_ready_o}); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.wkup_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_wkup_valid: got %0b want 0", bus.wkup_valid_o); end
        n_tests++; if (bus.wkup_rid_o !== 6'd0) begin n_fail++; $display("FAIL mid_wkup_rid: got %0d want 0", bus.wkup_rid_o); end
        n_tests++; if (bus.wkup_data_o !== 32'd0) begin n_fail++; $display("FAIL mid_wkup_data: got %h want 0", bus.wkup_data_o); end
        n_tests++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_wb_valid: got %0b want 0", bus.wb_valid_o); end
        n_tests++; if ({bus.wb_rid_o, bus.wb_data_o} !== 38'd0) begin n_fail++; $display("FAIL mid_wb_head: got %h want 0", {bus.wb_rid_o, bus.wb_data_o}); end
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %0b want 0", bus.err_o); end
        n_tests++; if (bus.fu_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", bus.fu_ready_o); end
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if ({bus.fu_ready_o, bus.wb_valid_o} !== 2'b10) begin n_fail++; $display("FAIL mid_release: got %b want 10", {bus.fu_ready_o, bus.wb_valid_o}); end
        $display("[TB] reset mid-stream checked");
    endtask

    initial begin
        idle_inputs();
        bus.wb_ready_i = 1'b0;
        do_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
